// File: rtl/regfile_sb_if.sv
// Register-file access bundle: writeback port, two read ports and scoreboard set/status.
interface regfile_sb_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5
);
    logic              ctrl_writeEnable;
    logic [ADDR_W-1:0] ctrl_writeReg;
    logic [DATA_W-1:0] data_writeReg;
    logic [ADDR_W-1:0] ctrl_readRegA;
    logic [ADDR_W-1:0] ctrl_readRegB;
    logic [DATA_W-1:0] data_readRegA;
    logic [DATA_W-1:0] data_readRegB;
    logic              sb_set;
    logic [ADDR_W-1:0] sb_setReg;
    logic              busy_A;
    logic              busy_B;
    logic              any_busy;

    modport master (
        output ctrl_writeEnable, ctrl_writeReg, data_writeReg,
        output ctrl_readRegA, ctrl_readRegB, sb_set, sb_setReg,
        input  data_readRegA, data_readRegB, busy_A, busy_B, any_busy
    );

    modport slave (
        input  ctrl_writeEnable, ctrl_writeReg, data_writeReg,
        input  ctrl_readRegA, ctrl_readRegB, sb_set, sb_setReg,
        output data_readRegA, data_readRegB, busy_A, busy_B, any_busy
    );
endinterface

// File: rtl/regfile_sb.sv
// Architectural register file (1W/2R, optional write bypass) with a per-register
// pending-write scoreboard used by decode to stall on outstanding multicycle ops.
module regfile_sb #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5,
    parameter bit          BYPASS = 1'b1
) (
    input  logic           clk,
    input  logic           clr,
    regfile_sb_if.slave    bus
);
    localparam int unsigned NREG = 1 << ADDR_W;

    logic [DATA_W-1:0] regs [NREG];
    logic [NREG-1:0]   busy;
    logic [NREG-1:0]   busy_nxt;

    logic              wr_hit;
    logic              set_hit;
    logic [DATA_W-1:0] rd_a;
    logic [DATA_W-1:0] rd_b;
    logic              bz_a;
    logic              bz_b;

    // Register 0 is never written and never marked busy.
    assign wr_hit  = bus.ctrl_writeEnable && (bus.ctrl_writeReg != '0);
    assign set_hit = bus.sb_set && (bus.sb_setReg != '0);

    // Writeback retires the pending bit; a same-cycle issue to the same register wins.
    always_comb begin
        busy_nxt = busy;
        if (wr_hit)
            busy_nxt[bus.ctrl_writeReg] = 1'b0;
        if (set_hit)
            busy_nxt[bus.sb_setReg] = 1'b1;
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            for (int i = 0; i < int'(NREG); i++)
                regs[i] <= '0;
            busy <= '0;
        end else begin
            if (wr_hit)
                regs[bus.ctrl_writeReg] <= bus.data_writeReg;
            busy <= busy_nxt;
        end
    end

    // Read ports: forwarding is suppressed during clr so outputs show the cleared state.
    always_comb begin
        rd_a = regs[bus.ctrl_readRegA];
        rd_b = regs[bus.ctrl_readRegB];
        bz_a = busy[bus.ctrl_readRegA];
        bz_b = busy[bus.ctrl_readRegB];
        if (BYPASS && !clr && wr_hit) begin
            if (bus.ctrl_writeReg == bus.ctrl_readRegA) begin
                rd_a = bus.data_writeReg;
                if (!(set_hit && (bus.sb_setReg == bus.ctrl_readRegA)))
                    bz_a = 1'b0;
            end
            if (bus.ctrl_writeReg == bus.ctrl_readRegB) begin
                rd_b = bus.data_writeReg;
                if (!(set_hit && (bus.sb_setReg == bus.ctrl_readRegB)))
                    bz_b = 1'b0;
            end
        end
    end

    assign bus.data_readRegA = rd_a;
    assign bus.data_readRegB = rd_b;
    assign bus.busy_A        = bz_a;
    assign bus.busy_B        = bz_b;
    assign bus.any_busy      = |busy;
endmodule

// File: tb/tb_regfile_sb.sv
// Randomized and directed bench for regfile_sb; checks a bypassing and a non-bypassing
// instance against an array-based reference model of the register file and scoreboard.
module tb_regfile_sb;
    logic clk = 1'b0;
    logic clr = 1'b1;
    always #5 clk = ~clk;

    logic        t_we = 1'b0;
    logic [4:0]  t_wr = '0;
    logic [31:0] t_wd = '0;
    logic [4:0]  t_ra = '0;
    logic [4:0]  t_rb = '0;
    logic        t_set = 1'b0;
    logic [4:0]  t_sr = '0;

    regfile_sb_if #(.DATA_W(32), .ADDR_W(5)) bus1 ();
    regfile_sb_if #(.DATA_W(32), .ADDR_W(5)) bus0 ();

    assign bus1.ctrl_writeEnable = t_we;  assign bus0.ctrl_writeEnable = t_we;
    assign bus1.ctrl_writeReg    = t_wr;  assign bus0.ctrl_writeReg    = t_wr;
    assign bus1.data_writeReg    = t_wd;  assign bus0.data_writeReg    = t_wd;
    assign bus1.ctrl_readRegA    = t_ra;  assign bus0.ctrl_readRegA    = t_ra;
    assign bus1.ctrl_readRegB    = t_rb;  assign bus0.ctrl_readRegB    = t_rb;
    assign bus1.sb_set           = t_set; assign bus0.sb_set           = t_set;
    assign bus1.sb_setReg        = t_sr;  assign bus0.sb_setReg        = t_sr;

    regfile_sb #(.DATA_W(32), .ADDR_W(5), .BYPASS(1'b1)) dut1 (.clk(clk), .clr(clr), .bus(bus1));
    regfile_sb #(.DATA_W(32), .ADDR_W(5), .BYPASS(1'b0)) dut0 (.clk(clk), .clr(clr), .bus(bus0));

    int tests = 0;
    int fails = 0;

    // Reference model state
    logic [31:0] mregs [32];
    logic        mbusy [32];

    function automatic void model_clear();
        for (int i = 0; i < 32; i++) begin
            mregs[i] = '0;
            mbusy[i] = 1'b0;
        end
    endfunction

    // Rising-edge rules: retire before issue, so a same-cycle issue leaves the bit set.
    function automatic void model_edge();
        if (clr) return;
        if (t_we && t_wr != 0) begin
            mregs[t_wr] = t_wd;
            mbusy[t_wr] = 1'b0;
        end
        if (t_set && t_sr != 0) mbusy[t_sr] = 1'b1;
    endfunction

    function automatic logic [31:0] exp_rd(bit byp, logic [4:0] ra);
        if (ra == 0 || clr) return 32'h0;
        if (byp && t_we && t_wr == ra) return t_wd;
        return mregs[ra];
    endfunction

    function automatic logic exp_busy(bit byp, logic [4:0] ra);
        if (ra == 0 || clr) return 1'b0;
        if (byp && t_we && t_wr == ra && !(t_set && t_sr == ra)) return 1'b0;
        return mbusy[ra];
    endfunction

    function automatic logic exp_any();
        logic a = 1'b0;
        for (int i = 1; i < 32; i++) a = a | mbusy[i];
        return a;
    endfunction

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle();
        t_we = 1'b0; t_set = 1'b0;
    endtask

    task automatic test_reset();
        model_clear();
        #3;
        tests++;
        if ({bus1.data_readRegA, bus1.busy_A, bus1.any_busy} !== 34'h0) begin
            fails++; $display("FAIL reset_init got %h exp 0", {bus1.data_readRegA, bus1.busy_A, bus1.any_busy});
        end
        @(negedge clk); clr = 1'b0;
        // Load r5 and mark it busy, then clear mid-cycle
        t_we = 1'b1; t_wr = 5'd5; t_wd = 32'h1234; t_set = 1'b1; t_sr = 5'd5; t_ra = 5'd5;
        tick(); idle();
        #1;
        tests++;
        if (bus1.data_readRegA !== 32'h1234 || bus1.busy_A !== 1'b1 || bus1.any_busy !== 1'b1) begin
            fails++; $display("FAIL reset_preload got %h/%b/%b exp 00001234/1/1", bus1.data_readRegA, bus1.busy_A, bus1.any_busy);
        end
        clr = 1'b1; model_clear();
        #1;
        tests++;
        if (bus1.data_readRegA !== 32'h0 || bus1.busy_A !== 1'b0 || bus1.any_busy !== 1'b0) begin
            fails++; $display("FAIL reset_async got %h/%b/%b exp 0/0/0", bus1.data_readRegA, bus1.busy_A, bus1.any_busy);
        end
        tests++;
        if (bus0.data_readRegA !== 32'h0 || bus0.busy_A !== 1'b0 || bus0.any_busy !== 1'b0) begin
            fails++; $display("FAIL reset_async_nb got %h/%b/%b exp 0/0/0", bus0.data_readRegA, bus0.busy_A, bus0.any_busy);
        end
        #1; clr = 1'b0;
    endtask

    task automatic test_write_read();
        t_we = 1'b1; t_wr = 5'd7; t_wd = 32'hDEADBEEF;
        tick(); idle();
        t_ra = 5'd7; t_rb = 5'd7; #1;
        tests++;
        if (bus1.data_readRegA !== 32'hDEADBEEF || bus1.data_readRegB !== 32'hDEADBEEF) begin
            fails++; $display("FAIL readback got %h/%h exp deadbeef", bus1.data_readRegA, bus1.data_readRegB);
        end
        tests++;
        if (bus0.data_readRegA !== 32'hDEADBEEF || bus0.data_readRegB !== 32'hDEADBEEF) begin
            fails++; $display("FAIL readback_nb got %h/%h exp deadbeef", bus0.data_readRegA, bus0.data_readRegB);
        end
        t_we = 1'b1; t_wr = 5'd0; t_wd = 32'hFFFFFFFF;
        tick(); idle();
        t_ra = 5'd0; t_rb = 5'd0; #1;
        tests++;
        if (bus1.data_readRegA !== 32'h0 || bus0.data_readRegB !== 32'h0) begin
            fails++; $display("FAIL r0_write got %h/%h exp 0", bus1.data_readRegA, bus0.data_readRegB);
        end
    endtask

    task automatic test_bypass();
        t_we = 1'b1; t_wr = 5'd3; t_wd = 32'h11;
        tick();
        t_wd = 32'h55; t_ra = 5'd3; #1;
        tests++;
        if (bus1.data_readRegA !== 32'h55) begin
            fails++; $display("FAIL bypass_fwd got %h exp 00000055", bus1.data_readRegA);
        end
        tests++;
        if (bus0.data_readRegA !== 32'h11) begin
            fails++; $display("FAIL bypass_off got %h exp 00000011", bus0.data_readRegA);
        end
        tick(); idle(); #1;
        tests++;
        if (bus1.data_readRegA !== 32'h55 || bus0.data_readRegA !== 32'h55) begin
            fails++; $display("FAIL bypass_after got %h/%h exp 55/55", bus1.data_readRegA, bus0.data_readRegA);
        end
    endtask

    task automatic test_scoreboard();
        t_set = 1'b1; t_sr = 5'd9; t_ra = 5'd9; #1;
        tests++;
        if (bus1.busy_A !== 1'b0 || bus1.any_busy !== 1'b0) begin
            fails++; $display("FAIL sb_same_cycle got %b/%b exp 0/0", bus1.busy_A, bus1.any_busy);
        end
        tick(); idle(); #1;
        tests++;
        if (bus1.busy_A !== 1'b1 || bus1.any_busy !== 1'b1 || bus0.busy_A !== 1'b1) begin
            fails++; $display("FAIL sb_set got %b/%b/%b exp 1/1/1", bus1.busy_A, bus1.any_busy, bus0.busy_A);
        end
        tick(); tick(); tick();
        t_we = 1'b1; t_wr = 5'd9; t_wd = 32'h42; #1;
        tests++;
        if (bus1.busy_A !== 1'b0 || bus0.busy_A !== 1'b1 || bus1.any_busy !== 1'b1) begin
            fails++; $display("FAIL sb_clear_bypass got %b/%b/%b exp 0/1/1", bus1.busy_A, bus0.busy_A, bus1.any_busy);
        end
        tick(); idle(); #1;
        tests++;
        if (bus1.busy_A !== 1'b0 || bus1.any_busy !== 1'b0 || bus0.busy_A !== 1'b0 || bus1.data_readRegA !== 32'h42) begin
            fails++; $display("FAIL sb_cleared got %b/%b/%b/%h exp 0/0/0/42", bus1.busy_A, bus1.any_busy, bus0.busy_A, bus1.data_readRegA);
        end
    endtask

    task automatic test_set_clear();
        t_set = 1'b1; t_sr = 5'd12;
        tick();
        t_we = 1'b1; t_wr = 5'd12; t_wd = 32'h99; t_ra = 5'd12; #1;
        tests++;
        if (bus1.busy_A !== 1'b1) begin
            fails++; $display("FAIL setclr_during got %b exp 1", bus1.busy_A);
        end
        tick(); idle(); #1;
        tests++;
        if (bus1.data_readRegA !== 32'h99 || bus1.busy_A !== 1'b1 || bus0.busy_A !== 1'b1) begin
            fails++; $display("FAIL setclr_after got %h/%b/%b exp 99/1/1", bus1.data_readRegA, bus1.busy_A, bus0.busy_A);
        end
        t_we = 1'b1; t_wr = 5'd12; t_wd = 32'h99;
        tick(); idle();
    endtask

    task automatic test_r0_sb();
        t_set = 1'b1; t_sr = 5'd0; t_ra = 5'd0;
        tick(); idle(); #1;
        tests++;
        if (bus1.busy_A !== 1'b0 || bus1.any_busy !== 1'b0 || bus0.any_busy !== 1'b0) begin
            fails++; $display("FAIL r0_busy got %b/%b/%b exp 0/0/0", bus1.busy_A, bus1.any_busy, bus0.any_busy);
        end
    endtask

    task automatic test_random();
        logic [66:0] got, exp;
        for (int n = 0; n < 400; n++) begin
            t_we  = ($urandom_range(0, 2) != 0);
            t_wr  = 5'($urandom_range(0, 7));
            t_wd  = $urandom;
            t_ra  = (n % 3 == 0) ? t_wr : 5'($urandom_range(0, 7));
            t_rb  = 5'($urandom);
            t_set = ($urandom_range(0, 3) == 0);
            t_sr  = (n % 5 == 0) ? t_wr : 5'($urandom_range(0, 7));
            #1;
            got = {bus1.data_readRegA, bus1.data_readRegB, bus1.busy_A, bus1.busy_B, bus1.any_busy};
            exp = {exp_rd(1'b1, t_ra), exp_rd(1'b1, t_rb), exp_busy(1'b1, t_ra), exp_busy(1'b1, t_rb), exp_any()};
            tests++;
            if (got !== exp) begin
                fails++; $display("FAIL rand_byp[%0d] got %h exp %h", n, got, exp);
            end
            got = {bus0.data_readRegA, bus0.data_readRegB, bus0.busy_A, bus0.busy_B, bus0.any_busy};
            exp = {exp_rd(1'b0, t_ra), exp_rd(1'b0, t_rb), exp_busy(1'b0, t_ra), exp_busy(1'b0, t_rb), exp_any()};
            tests++;
            if (got !== exp) begin
                fails++; $display("FAIL rand_nobyp[%0d] got %h exp %h", n, got, exp);
            end
            tick();
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_bypass();
        test_scoreboard();
        test_set_clear();
        test_r0_sb();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Architectural register file for the pipelined processor, built from per-bit enabled, asynchronously cleared storage.
- Sits directly downstream of the writeback stage and upstream of decode/operand fetch.
- Provides one synchronous write port and two combinational read ports, with optional write-to-read bypass.
- Adds a pending-write scoreboard: one busy bit per register, set when a multicycle op (mult/div) issues and cleared when its result is written back. Decode uses it to stall.

Parameters:
- DATA_W, 32, register data width in bits
- ADDR_W, 5, register index width; register count = 2**ADDR_W
- BYPASS, 1, 1 = same-cycle write data forwarded to reads and busy cleared same cycle; 0 = no forwarding

Ports:
- clk  input  1  clock, all state updates on rising edge
- clr  input  1  asynchronous active-high reset
- ctrl_writeEnable  input  1  write request this cycle
- ctrl_writeReg  input  ADDR_W  destination register index
- data_writeReg  input  DATA_W  write data
- ctrl_readRegA  input  ADDR_W  read port A index
- ctrl_readRegB  input  ADDR_W  read port B index
- data_readRegA  output  DATA_W  read port A data
- data_readRegB  output  DATA_W  read port B data
- sb_set  input  1  mark a register pending (multicycle op issued)
- sb_setReg  input  ADDR_W  register index to mark pending
- busy_A  output  1  register at ctrl_readRegA is pending
- busy_B  output  1  register at ctrl_readRegB is pending
- any_busy  output  1  OR of all busy bits

Behaviour:
- Reset is clk, clr: asynchronous, active-high.
  - clr high clears all registers to 0 and all busy bits to 0 immediately, independent of clk.
  - While clr is high, writes and sb_set are ignored.
  - Read outputs reflect the cleared state combinationally. At reset, data_readRegA/B = 0, busy_A/B = 0, any_busy = 0.
  - clr asserted mid-operation discards all pending busy state. No write in progress survives.
- Initial simulation state of all storage is 0.
- Write:
  - On a rising clk with ctrl_writeEnable=1 and ctrl_writeReg != 0, reg[ctrl_writeReg] <= data_writeReg.
  - Latency: 1 cycle to storage.
  - Writes to register 0 are dropped.
- Register 0: always reads 0, never busy. sb_set with sb_setReg=0 is ignored.
- Read, combinational:
  - data_readRegX = reg[ctrl_readRegX].
  - If BYPASS=1, ctrl_writeEnable=1, ctrl_writeReg == ctrl_readRegX, and the index is nonzero, then data_readRegX = data_writeReg in the same cycle.
  - Both ports are independent and may address the same register.
- Scoreboard, per register i != 0, on rising clk:
  - Set condition: sb_set=1 and sb_setReg == i.
  - Clear condition: ctrl_writeEnable=1 and ctrl_writeReg == i.
  - Set and clear to the same i in the same cycle: set wins, and busy[i] ends at 1. A new op was issued while the older result retires; the data is still written.
  - Set on an already-busy register keeps it at 1. No counting; one outstanding op per register.
  - Clear on a non-busy register leaves it at 0. The normal single-cycle writeback path has no side effect.
- busy_X:
  - Base value is busy[ctrl_readRegX].
  - If BYPASS=1 and a clearing write to that same nonzero register is present this cycle without a same-cycle set, busy_X = 0.
  - busy_X never reflects a same-cycle sb_set. Decode sees the new busy bit starting the next cycle.
- any_busy = OR of the registered busy bits only (no bypass).
- Out-of-range indices do not exist; every ADDR_W value is valid.

Test Plan:
- Reset: clr=1 pulse mid-cycle after loading r5=0x1234 and marking r5 busy -> data_readRegA(r5)=0, busy_A=0, any_busy=0 immediately, without waiting for a clk edge.
- Write/readback: write r7=0xDEADBEEF at edge N; read A=r7, B=r7 at N+1 -> both 0xDEADBEEF. Write r0=0xFFFFFFFF -> r0 reads 0.
- Bypass (BYPASS=1): same cycle ctrl_writeEnable=1, writeReg=r3, data=0x55, readRegA=r3 (old value 0x11) -> data_readRegA=0x55 before the edge, 0x55 after. With BYPASS=0 -> 0x11 before the edge, 0x55 after.
- Scoreboard lifecycle: sb_set r9 at edge N -> busy_A(r9)=0 during cycle N, 1 from N+1, any_busy=1. Write r9=0x42 at edge N+4 -> (BYPASS=1) busy_A=0 during that write cycle. busy bit 0 after N+4, any_busy=0.
- Simultaneous set+clear: sb_set r12 and write r12=0x99 in the same cycle while r12 is busy -> after the edge, r12 reads 0x99 and busy_A(r12)=1.
- r0 scoreboard: sb_set with sb_setReg=0 -> busy_A(r0)=0 and any_busy=0 on the next cycle.
